// File: rtl/some_vip_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte channel of the DUT
// between N_REQ requesters. A grant lasts at most MAX_BURST accepted beats
// or until the granted requester drops valid. The byte the DUT returns for
// each beat is routed back to the requester that issued it, two cycles after
// the transfer.
module some_vip_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    dut_valid_o,
  output logic [DATA_W-1:0]       dut_data_o,
  input  logic                    dut_ready_i,
  input  logic [DATA_W-1:0]       dut_data_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   last_gnt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [IDX_W-1:0]   next_idx;
  logic               found;
  logic               xfer;

  logic               s1_valid;
  logic [IDX_W-1:0]   s1_idx;
  logic               s2_valid;
  logic [IDX_W-1:0]   s2_idx;
  logic [DATA_W-1:0]  s2_data;

  // Round-robin search: first requesting index strictly after last_gnt, with wrap.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise the tool infers a latch to hold the old value.
    next_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_valid_i[(int'(last_gnt) + k) % N_REQ]) begin
        found    = 1'b1;
        next_idx = IDX_W'((int'(last_gnt) + k) % N_REQ);
      end
    end
  end

  // Combinational forwarding between the granted requester and the DUT port.
  always_comb begin
    req_ready_o = '0;
    dut_valid_o = 1'b0;
    dut_data_o  = '0;
    grant_o     = '0;
    busy_o      = 1'b0;
    if (state == GRANT) begin
      dut_valid_o          = req_valid_i[gnt_idx];
      dut_data_o           = req_data_i[gnt_idx*DATA_W +: DATA_W];
      req_ready_o[gnt_idx] = dut_ready_i;
      grant_o[gnt_idx]     = 1'b1;
      busy_o               = 1'b1;
    end
  end

  assign xfer = dut_valid_o & dut_ready_i;

  // Grant FSM: pick a winner in IDLE, count beats and release in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_gnt <= IDX_W'(N_REQ - 1);
      beat_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx  <= next_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid_i[gnt_idx]) begin
            state    <= IDLE;
            last_gnt <= gnt_idx;
          end else if (xfer) begin
            if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
              beat_cnt <= CNT_W'(MAX_BURST);
              state    <= IDLE;
              last_gnt <= gnt_idx;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response pipeline: stage 1 remembers who transferred, stage 2 captures the DUT byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= xfer;
      s1_idx   <= gnt_idx;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_data  <= s1_valid ? dut_data_i : '0;
    end
  end

  // One-hot response strobe decoded from stage 2.
  always_comb begin
    rsp_valid_o = '0;
    if (s2_valid) rsp_valid_o[s2_idx] = 1'b1;
  end

  assign rsp_data_o = s2_data;

endmodule
